// File: rtl/idex_stage_reg_pkg.sv
// ---------------------------------------------------------------------------
// idex_pkg
// Shared definitions for the ID->EX pipeline stage register.
//   - default widths for the payload, control bundle and perf counters
//   - bit positions of each field inside the control bundle
//   - occupancy state encoding of the stage
// ---------------------------------------------------------------------------
package idex_pkg;

  // Default widths
  localparam int DEFAULT_DATA_W = 138;
  localparam int DEFAULT_CTRL_W = 16;
  localparam int DEFAULT_CNT_W  = 16;

  // Control bundle layout, LSB first
  localparam int CTRL_REGDST      = 0;
  localparam int CTRL_JUMP        = 1;
  localparam int CTRL_BRANCH      = 2;
  localparam int CTRL_MEMREAD     = 3;
  localparam int CTRL_MEMTOREG    = 4;
  localparam int CTRL_MEMWRITE    = 5;
  localparam int CTRL_ALUSRC      = 6;
  localparam int CTRL_REGWRITE    = 7;
  localparam int CTRL_ALUOP_LSB   = 8;
  localparam int CTRL_ALUOP_W     = 2;
  localparam int CTRL_OPCODE_LSB  = 10;
  localparam int CTRL_OPCODE_W    = 6;

  // Stage occupancy: TWO is only reachable when the skid entry exists
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

endpackage

// File: rtl/idex_stage_reg_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Saturating up-counter used for stage performance debug. Holds at all-ones
// instead of wrapping so a long stall never reads back as a small number.
// Ports:
//   clock   in   rising-edge clock
//   reset_n in   synchronous active-low reset, clears the count
//   inc     in   add one this cycle (ignored once saturated)
//   count   out  current count
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Count up until every bit is set, then hold
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/idex_stage_reg.sv
// ---------------------------------------------------------------------------
// idex_stage_reg
// ID->EX pipeline stage register with valid/ready handshake, optional skid
// entry, synchronous flush, bubble insertion and saturating perf counters.
// Ports:
//   clock      in   rising-edge clock
//   reset_n    in   synchronous active-low reset
//   in_valid   in   decode offers an instruction
//   in_ready   out  stage accepts this cycle (registered when SKID=1)
//   in_ctrl    in   control bundle from decode
//   in_data    in   payload from decode/register read
//   flush      in   drop every held entry and the beat offered this cycle
//   out_valid  out  an entry is presented to execute
//   out_ready  in   execute consumes this cycle
//   out_ctrl   out  held control bundle, zero whenever out_valid=0
//   out_data   out  held payload, keeps last value when out_valid=0
//   stall_cnt  out  cycles with out_valid=1 and out_ready=0 (saturating)
//   bubble_cnt out  cycles with out_valid=0 (saturating)
// ---------------------------------------------------------------------------
module idex_stage_reg
  import idex_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int CTRL_W = DEFAULT_CTRL_W,
  parameter int SKID   = 1,
  parameter int CNT_W  = DEFAULT_CNT_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  state_t            state;
  state_t            state_next;
  logic [CTRL_W-1:0] main_ctrl;
  logic [CTRL_W-1:0] main_ctrl_next;
  logic [DATA_W-1:0] main_data;
  logic [DATA_W-1:0] main_data_next;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [CTRL_W-1:0] skid_ctrl_next;
  logic [DATA_W-1:0] skid_data;
  logic [DATA_W-1:0] skid_data_next;
  logic              in_ready_q;
  logic              in_xfer;
  logic              out_xfer;

  assign out_valid = (state != EMPTY);

  // With a skid entry, ready comes straight from a flop so upstream sees no
  // combinational path from out_ready; without it, ready is the classic
  // "consumer ready or stage empty".
  assign in_ready = (SKID != 0) ? in_ready_q : (out_ready | ~out_valid);

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  // Next-state and entry steering. Flush overrides everything, including a
  // beat offered in the same cycle. In ONE with only an input transfer the
  // new beat lands in skid; with SKID=0 that case cannot occur because
  // in_ready then requires out_ready while an entry is held.
  always_comb begin
    state_next     = state;
    main_ctrl_next = main_ctrl;
    main_data_next = main_data;
    skid_ctrl_next = skid_ctrl;
    skid_data_next = skid_data;

    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_xfer) begin
            state_next     = ONE;
            main_ctrl_next = in_ctrl;
            main_data_next = in_data;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            main_ctrl_next = in_ctrl;
            main_data_next = in_data;
          end else if (in_xfer) begin
            state_next     = TWO;
            skid_ctrl_next = in_ctrl;
            skid_data_next = in_data;
          end else if (out_xfer) begin
            state_next = EMPTY;
          end
        end
        TWO: begin
          if (out_xfer) begin
            state_next     = ONE;
            main_ctrl_next = skid_ctrl;
            main_data_next = skid_data;
          end
        end
        default: begin
          state_next = EMPTY;
        end
      endcase
    end
  end

  // State and entry registers. in_ready_q looks ahead at the next state so it
  // drops exactly when the skid entry becomes occupied.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= EMPTY;
      main_ctrl  <= '0;
      main_data  <= '0;
      skid_ctrl  <= '0;
      skid_data  <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_next;
      main_ctrl  <= main_ctrl_next;
      main_data  <= main_data_next;
      skid_ctrl  <= skid_ctrl_next;
      skid_data  <= skid_data_next;
      in_ready_q <= (state_next != TWO);
    end
  end

  // Bubble: an empty stage presents an all-zero control bundle so nothing
  // downstream can write a register or memory, whatever main still holds.
  assign out_ctrl = out_valid ? main_ctrl : '0;
  assign out_data = main_data;

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (out_valid & ~out_ready),
    .count   (stall_cnt)
  );

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_bubble_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (~out_valid),
    .count   (bubble_cnt)
  );

endmodule

// File: tb/tb_idex_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_idex_stage_reg
// Directed bench for idex_stage_reg. Three instances share one stimulus:
//   dut_a  SKID=1, CNT_W=16  main checked instance
//   dut_s  SKID=1, CNT_W=4   counter saturation
//   dut_c  SKID=0, CNT_W=16  combinational in_ready
// ---------------------------------------------------------------------------
module tb_idex_stage_reg;

  localparam int DW = 138;
  localparam int CW = 16;

  logic          clock;
  logic          reset_n;
  logic          in_valid;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          flush;
  logic          out_ready;

  logic          a_in_ready, a_out_valid;
  logic [CW-1:0] a_out_ctrl;
  logic [DW-1:0] a_out_data;
  logic [15:0]   a_stall, a_bubble;

  logic          s_in_ready, s_out_valid;
  logic [CW-1:0] s_out_ctrl;
  logic [DW-1:0] s_out_data;
  logic [3:0]    s_stall, s_bubble;

  logic          c_in_ready, c_out_valid;
  logic [CW-1:0] c_out_ctrl;
  logic [DW-1:0] c_out_data;
  logic [15:0]   c_stall, c_bubble;

  int checks   = 0;
  int failures = 0;

  // Expected-counter model, driven by the bench's own expected out_valid
  logic cur_valid  = 1'b0;
  int   exp_stall  = 0;
  int   exp_bubble = 0;

  typedef struct {
    logic          iv;
    logic [CW-1:0] ic;
    logic [DW-1:0] id;
    logic          ordy;
    logic          fl;
    logic          ev;
    logic [CW-1:0] ec;
    logic [DW-1:0] ed;
    logic          er;
  } vec_t;

  vec_t vecs [9];

  idex_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(16)) dut_a (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush), .out_valid(a_out_valid),
    .out_ready(out_ready), .out_ctrl(a_out_ctrl), .out_data(a_out_data),
    .stall_cnt(a_stall), .bubble_cnt(a_bubble)
  );

  idex_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(4)) dut_s (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush), .out_valid(s_out_valid),
    .out_ready(out_ready), .out_ctrl(s_out_ctrl), .out_data(s_out_data),
    .stall_cnt(s_stall), .bubble_cnt(s_bubble)
  );

  idex_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(16)) dut_c (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(c_in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush), .out_valid(c_out_valid),
    .out_ready(out_ready), .out_ctrl(c_out_ctrl), .out_data(c_out_data),
    .stall_cnt(c_stall), .bubble_cnt(c_bubble)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic applyStimulus(input logic iv, input logic [CW-1:0] ic,
                               input logic [DW-1:0] id, input logic ordy,
                               input logic fl);
    in_valid  = iv;
    in_ctrl   = ic;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic checkOutput(input string name, input logic [DW-1:0] act,
                             input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One clock edge; the counter model uses pre-edge expected out_valid
  task automatic step(input logic nxt_valid);
    if (!reset_n) begin
      exp_stall  = 0;
      exp_bubble = 0;
    end else begin
      if (cur_valid && !out_ready) exp_stall++;
      if (!cur_valid) exp_bubble++;
    end
    @(posedge clock);
    #1;
    cur_valid = nxt_valid;
  endtask

  task automatic checkStage(input string name, input logic ev,
                            input logic [CW-1:0] ec, input logic [DW-1:0] ed,
                            input logic er);
    checkOutput({name, ".out_valid"}, {137'd0, a_out_valid}, {137'd0, ev});
    checkOutput({name, ".out_ctrl"},  {122'd0, a_out_ctrl},  {122'd0, ec});
    checkOutput({name, ".out_data"},  a_out_data, ed);
    checkOutput({name, ".in_ready"},  {137'd0, a_in_ready},  {137'd0, er});
  endtask

  task automatic checkCounters(input string name);
    int s4, b4;
    s4 = (exp_stall  > 15) ? 15 : exp_stall;
    b4 = (exp_bubble > 15) ? 15 : exp_bubble;
    checkOutput({name, ".stall_cnt"},    {122'd0, a_stall},  DW'(exp_stall));
    checkOutput({name, ".bubble_cnt"},   {122'd0, a_bubble}, DW'(exp_bubble));
    checkOutput({name, ".stall_cnt4"},   {134'd0, s_stall},  DW'(s4));
    checkOutput({name, ".bubble_cnt4"},  {134'd0, s_bubble}, DW'(b4));
  endtask

  initial begin
    int b0;

    // ---------------- reset ----------------
    reset_n = 1'b0;
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    step(1'b0);
    checkStage("reset", 1'b0, '0, '0, 1'b1);
    checkCounters("reset");
    checkOutput("reset.c_in_ready",  {137'd0, c_in_ready},  {137'd0, 1'b1});
    checkOutput("reset.c_out_valid", {137'd0, c_out_valid}, '0);
    reset_n = 1'b1;

    // ---------------- streaming table ----------------
    for (int i = 0; i < 8; i++) begin
      vecs[i] = '{iv: 1'b1, ic: 16'h0100 + 16'(i), id: DW'(i), ordy: 1'b1, fl: 1'b0,
                  ev: 1'b1, ec: 16'h0100 + 16'(i), ed: DW'(i), er: 1'b1};
    end
    vecs[8] = '{iv: 1'b0, ic: 16'hBEEF, id: DW'(99), ordy: 1'b1, fl: 1'b0,
                ev: 1'b0, ec: 16'h0000, ed: DW'(7), er: 1'b1};

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].iv, vecs[i].ic, vecs[i].id, vecs[i].ordy, vecs[i].fl);
      step(vecs[i].ev);
      checkStage($sformatf("stream%0d", i), vecs[i].ev, vecs[i].ec, vecs[i].ed, vecs[i].er);
    end
    checkCounters("stream");

    // ---------------- backpressure ----------------
    applyStimulus(1'b1, 16'h0200, DW'('h20), 1'b1, 1'b0);
    step(1'b1);
    checkStage("bp_load", 1'b1, 16'h0200, DW'('h20), 1'b1);

    applyStimulus(1'b1, 16'h0201, DW'('h21), 1'b0, 1'b0);
    step(1'b1);
    checkStage("bp_stall1", 1'b1, 16'h0200, DW'('h20), 1'b0);

    applyStimulus(1'b1, 16'h0202, DW'('h22), 1'b0, 1'b0);
    step(1'b1);
    checkStage("bp_stall2", 1'b1, 16'h0200, DW'('h20), 1'b0);
    step(1'b1);
    checkStage("bp_stall3", 1'b1, 16'h0200, DW'('h20), 1'b0);
    checkCounters("bp_stall");

    out_ready = 1'b1;
    step(1'b1);
    checkStage("bp_drain1", 1'b1, 16'h0201, DW'('h21), 1'b1);
    step(1'b1);
    checkStage("bp_drain2", 1'b1, 16'h0202, DW'('h22), 1'b1);

    // ---------------- flush in TWO ----------------
    applyStimulus(1'b1, 16'h0203, DW'('h23), 1'b0, 1'b0);
    step(1'b1);
    checkStage("fl_two", 1'b1, 16'h0202, DW'('h22), 1'b0);

    applyStimulus(1'b1, 16'h0204, DW'('h24), 1'b0, 1'b1);
    step(1'b0);
    checkStage("fl_edge", 1'b0, 16'h0000, DW'('h22), 1'b1);
    checkCounters("fl_edge");

    applyStimulus(1'b0, 16'h0000, DW'(0), 1'b1, 1'b0);
    step(1'b0);
    checkStage("fl_after", 1'b0, 16'h0000, DW'('h22), 1'b1);

    // ---------------- bubbles ----------------
    b0 = exp_bubble;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 16'hFFFF, DW'('h3F), 1'b1, 1'b0);
      step(1'b0);
      checkOutput($sformatf("bubble%0d.out_ctrl", i), {122'd0, a_out_ctrl}, '0);
    end
    checkOutput("bubble.delta", {122'd0, a_bubble}, DW'(b0 + 5));

    // ---------------- saturation ----------------
    applyStimulus(1'b1, 16'h0280, DW'('h80), 1'b0, 1'b0);
    step(1'b1);
    applyStimulus(1'b0, 16'h0000, DW'(0), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1);
    checkOutput("sat.stall_cnt4", {134'd0, s_stall}, DW'(15));
    checkCounters("sat");

    // ---------------- reset with two entries held ----------------
    applyStimulus(1'b1, 16'h0300, DW'('h30), 1'b0, 1'b0);
    step(1'b1);
    checkStage("rst_two", 1'b1, 16'h0280, DW'('h80), 1'b0);
    reset_n = 1'b0;
    applyStimulus(1'b1, 16'h0301, DW'('h31), 1'b0, 1'b0);
    step(1'b0);
    checkStage("rst_mid", 1'b0, '0, '0, 1'b1);
    checkCounters("rst_mid");
    reset_n = 1'b1;

    // ---------------- SKID=0 combinational ready ----------------
    applyStimulus(1'b1, 16'h0400, DW'('h40), 1'b0, 1'b0);
    step(1'b1);
    checkOutput("c_load.out_ctrl", {122'd0, c_out_ctrl}, {122'd0, 16'h0400});
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    checkOutput("c_ready_lo", {137'd0, c_in_ready}, '0);
    checkOutput("a_ready_reg", {137'd0, a_in_ready}, {137'd0, 1'b1});
    out_ready = 1'b1;
    #1;
    checkOutput("c_ready_hi", {137'd0, c_in_ready}, {137'd0, 1'b1});
    out_ready = 1'b0;
    #1;
    checkOutput("c_ready_lo2", {137'd0, c_in_ready}, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
